knn_result_writer: RTL

//  Downstream stage of the per-query sorted top-K list. Captures the K sorted {l2_dist, merged_idx}

---
 rtl/knn_result_writer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/knn_result_writer.sv
// Two-slot ping-pong buffer for per-query sorted top-K snapshots, drained
// rank by rank (nearest first) over a valid/ready port with a query tag per beat.
module knn_result_writer #(
    parameter int DIST_W = 25,
    parameter int IDX_W  = 15,
    parameter int QIDX_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [DIST_W-1:0] l2_dist_0,
    input  logic [DIST_W-1:0] l2_dist_1,
    input  logic [DIST_W-1:0] l2_dist_2,
    input  logic [DIST_W-1:0] l2_dist_3,
    input  logic [IDX_W-1:0]  merged_idx_0,
    input  logic [IDX_W-1:0]  merged_idx_1,
    input  logic [IDX_W-1:0]  merged_idx_2,
    input  logic [IDX_W-1:0]  merged_idx_3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIST_W-1:0] out_dist,
    output logic [IDX_W-1:0]  out_idx,
    output logic [1:0]        out_rank,
    output logic [QIDX_W-1:0] out_qidx,
    output logic              out_last,
    output logic [1:0]        occupancy,
    output logic              overflow,
    output logic              o_dbg_state
);
    // Handshake: a beat transfers on any rising edge where out_valid & out_ready;
    // once raised, out_valid and the beat fields hold until that transfer.
    localparam int K = 4;

    typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIST_W-1:0] r_dist [2][K];
    logic [IDX_W-1:0]  r_idx  [2][K];
    logic [QIDX_W-1:0] r_tag  [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_occ;
    logic [1:0]        w_occ_nxt;
    logic [1:0]        r_rank;
    logic [QIDX_W-1:0] r_qcnt;
    logic              r_ovf;
    logic              w_hs;
    logic              w_pop;
    logic              w_accept;

    assign w_hs     = (r_state == S_DRAIN) & out_ready;
    assign w_pop    = w_hs & (r_rank == 2'(K - 1));
    // A full buffer still accepts when the head's final beat leaves this cycle.
    assign w_accept = valid_in & ((r_occ != 2'd2) | w_pop);

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_accept, w_pop})
            2'b10:   w_occ_nxt = r_occ + 2'd1;
            2'b01:   w_occ_nxt = r_occ - 2'd1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_occ_nxt == 2'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_occ   <= 2'd0;
            r_rank  <= 2'd0;
            r_qcnt  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_occ   <= w_occ_nxt;
            if (w_hs)
                r_rank <= w_pop ? 2'd0 : r_rank + 2'd1;
            if (w_pop)
                r_head <= ~r_head;
            if (w_accept)
                r_tail <= ~r_tail;
            if (valid_in)
                r_qcnt <= r_qcnt + 1'b1;
            if (valid_in && !w_accept)
                r_ovf <= 1'b1;
        end
    end

    // Slot payload needs no reset: it is only visible while its slot is occupied.
    always_ff @(posedge clk) begin
        if (rst_n && w_accept) begin
            r_dist[r_tail][0] <= l2_dist_0;
            r_dist[r_tail][1] <= l2_dist_1;
            r_dist[r_tail][2] <= l2_dist_2;
            r_dist[r_tail][3] <= l2_dist_3;
            r_idx[r_tail][0]  <= merged_idx_0;
            r_idx[r_tail][1]  <= merged_idx_1;
            r_idx[r_tail][2]  <= merged_idx_2;
            r_idx[r_tail][3]  <= merged_idx_3;
            r_tag[r_tail]     <= r_qcnt;
        end
    end

    assign out_valid   = (r_state == S_DRAIN);
    assign out_dist    = out_valid ? r_dist[r_head][r_rank] : '0;
    assign out_idx     = out_valid ? r_idx[r_head][r_rank] : '0;
    assign out_rank    = out_valid ? r_rank : 2'd0;
    assign out_qidx    = out_valid ? r_tag[r_head] : '0;
    assign out_last    = out_valid & (r_rank == 2'(K - 1));
    assign occupancy   = r_occ;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;

endmodule
